// File: rtl/packet_framer.sv
// packet_framer: collects payload words, appends a CRC and 2-D row/column parity, then emits one row per beat.
// Error injection is compiled in only when PKT_FRAMER_ERR_INJ_EN is defined; otherwise the mask ports are inert.
module packet_framer #(
  parameter int              ROWS     = 8,
  parameter int              ROW_DW   = 7,
  parameter int              IN_W     = 8,
  parameter logic [ROWS-1:0] CRC_POLY = ROWS'(8'h07)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IN_W-1:0]            in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  input  logic [ROWS*(ROW_DW+1)-1:0] err_inj_mask,
  input  logic                       err_inj_enable,
  output logic [ROW_DW+2:0]          out_row,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sof,
  output logic                       out_eof,
  output logic [15:0]                frame_cnt
);

  localparam int ROW_W  = ROW_DW + 3;
  localparam int W_W    = ROW_DW + 1;
  localparam int NWORDS = ROWS * ROW_DW / IN_W;
  localparam int LO_W   = (ROW_DW + 1) / 2;
  localparam int PAY_W  = ROWS * ROW_DW;
  localparam int WC_W   = $clog2(NWORDS + 1);
  localparam int RI_W   = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, ENCODE, EMIT} state_t;
  typedef logic [ROWS-1:0][ROW_W-1:0] rows_t;
  typedef logic [ROWS-1:0][W_W-1:0]   words_t;

  state_t              state, state_next;
  logic [PAY_W-1:0]    payload, payload_next;
  logic [ROWS-1:0]     crc, crc_next, crc_pad;
  logic [WC_W-1:0]     word_cnt;
  logic [RI_W-1:0]     row_idx, row_idx_next;
  rows_t               row_buf, row_enc;
  words_t              w, w_inj;
  logic [ROWS-1:0]     r_par, c_par;
  logic [ROWS*W_W-1:0] inj;
  logic                accept, last_word, row_taken, row_final;

  // Bit-serial CRC over one word, MSB first, no reflection.
  function automatic logic [ROWS-1:0] crc_word(input logic [ROWS-1:0] c_in,
                                               input logic [IN_W-1:0] word);
    logic [ROWS-1:0] c;
    logic            fb;
    c = c_in;
    for (int b = IN_W - 1; b >= 0; b--) begin
      fb = c[ROWS-1] ^ word[b];
      c  = {c[ROWS-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
    return c;
  endfunction

  assign accept       = in_valid && in_ready;
  assign last_word    = in_last || (word_cnt == WC_W'(NWORDS - 1));
  assign row_taken    = out_valid && out_ready;
  assign row_final    = (row_idx == RI_W'(ROWS - 1));
  assign row_idx_next = row_idx + 1'b1;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, COLLECT: if (accept) state_next = last_word ? ENCODE : COLLECT;
      ENCODE:        state_next = EMIT;
      EMIT:          if (row_taken && row_final) state_next = IDLE;
      default:       state_next = IDLE;
    endcase
  end

`ifdef PKT_FRAMER_ERR_INJ_EN
  logic [ROWS*W_W-1:0] inj_mask;
  logic                inj_en;

  // Mask and enable are frozen on the first word so a frame sees one consistent setting.
  always_ff @(posedge clk) begin
    if (rst) begin
      inj_mask <= '0;
      inj_en   <= 1'b0;
    end else if (accept && state == IDLE) begin
      inj_mask <= err_inj_mask;
      inj_en   <= err_inj_enable;
    end
  end

  assign inj = inj_en ? inj_mask : '0;
`else
  logic unused_inj;
  assign unused_inj = ^{err_inj_mask, err_inj_enable};
  assign inj        = '0;
`endif

  always_comb begin
    payload_next = (state == IDLE) ? '0 : payload;
    payload_next[int'(word_cnt)*IN_W +: IN_W] = in_data;
    crc_next = crc_word((state == IDLE) ? '0 : crc, in_data);
  end

  // Short frames still run the CRC over all NWORDS words, the missing ones as zeros.
  always_comb begin
    crc_pad = crc;
    w       = '0;
    w_inj   = '0;
    r_par   = '0;
    c_par   = '0;
    row_enc = '0;
    for (int n = 0; n < NWORDS; n++) begin
      if (WC_W'(n) >= word_cnt) crc_pad = crc_word(crc_pad, '0);
    end
    for (int i = 0; i < ROWS; i++) begin
      w[i]     = {crc_pad[i], payload[i*ROW_DW +: ROW_DW]};
      r_par[i] = ^w[i];
      c_par    = c_par ^ w[i];
      w_inj[i] = w[i] ^ inj[i*W_W +: W_W];
    end
    for (int i = 0; i < ROWS; i++) begin
      row_enc[i] = {c_par[i], w_inj[i][W_W-1], w_inj[i][ROW_DW-1:LO_W],
                    r_par[i], w_inj[i][LO_W-1:0]};
    end
  end

  // NOTE: row_buf is a handful of flops rather than a RAM, so it is cleared with everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      payload   <= '0;
      crc       <= '0;
      word_cnt  <= '0;
      row_buf   <= '0;
      row_idx   <= '0;
      out_row   <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      in_ready <= (state_next == IDLE) || (state_next == COLLECT);
      case (state)
        IDLE, COLLECT: begin
          if (accept) begin
            payload  <= payload_next;
            crc      <= crc_next;
            word_cnt <= word_cnt + 1'b1;
          end
        end
        ENCODE: begin
          row_buf   <= row_enc;
          out_row   <= row_enc[0];
          out_valid <= 1'b1;
          out_sof   <= 1'b1;
          out_eof   <= 1'b0;
          row_idx   <= '0;
          word_cnt  <= '0;
        end
        EMIT: begin
          if (row_taken) begin
            if (row_final) begin
              out_row   <= '0;
              out_valid <= 1'b0;
              out_sof   <= 1'b0;
              out_eof   <= 1'b0;
              frame_cnt <= frame_cnt + 1'b1;
            end else begin
              row_idx <= row_idx_next;
              out_row <= row_buf[row_idx_next];
              out_sof <= 1'b0;
              out_eof <= (row_idx_next == RI_W'(ROWS - 1));
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
